// File: rtl/if_id_branch_stage_if.sv
// ---------------------------------------------------------------------------
// if_id_branch_stage_if
//   Bundles the IF/ID stage signals exchanged between the if_id_branch_stage
//   block and the surrounding pipeline.
//   master : pipeline side; drives fetch/forwarding/hazard inputs and
//            observes the registered instruction, operands and control.
//   slave  : if_id_branch_stage side.
// ---------------------------------------------------------------------------
interface if_id_branch_stage_if #(
    parameter int DATA_W     = 32,
    parameter int PERF_CNT_W = 16
);
    // Fetch side
    logic [DATA_W-1:0]     IF_Instr;
    logic [DATA_W-1:0]     IF_PC_Plus4;
    // Register file and forwarding sources
    logic [DATA_W-1:0]     RF_Read1;
    logic [DATA_W-1:0]     RF_Read2;
    logic [1:0]            ID_Forward_1;
    logic [1:0]            ID_Forward_2;
    logic [DATA_W-1:0]     EX_MEM_ALUOut;
    logic [DATA_W-1:0]     MEM_WB_WriteData;
    // Downstream hazard information
    logic                  ID_EX_RegWrite;
    logic                  ID_EX_MemRead;
    logic [4:0]            ID_EX_Rd;
    logic                  EX_MEM_MemRead;
    logic [4:0]            EX_MEM_Rd;
    // Registered IF/ID contents
    logic [DATA_W-1:0]     IF_ID_Instr;
    logic [DATA_W-1:0]     IF_ID_PC_Plus4;
    logic [4:0]            IF_ID_Rs;
    logic [4:0]            IF_ID_Rt;
    // ID-stage results
    logic [DATA_W-1:0]     ID_Rs_Data;
    logic [DATA_W-1:0]     ID_Rt_Data;
    logic                  PC_Write;
    logic                  Branch_Taken;
    logic [DATA_W-1:0]     Branch_Target;
    logic                  ID_EX_Bubble;
    logic [PERF_CNT_W-1:0] Stall_Count;
    logic [PERF_CNT_W-1:0] Flush_Count;

    modport master (
        output IF_Instr, IF_PC_Plus4, RF_Read1, RF_Read2,
               ID_Forward_1, ID_Forward_2, EX_MEM_ALUOut, MEM_WB_WriteData,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
        input  IF_ID_Instr, IF_ID_PC_Plus4, IF_ID_Rs, IF_ID_Rt,
               ID_Rs_Data, ID_Rt_Data, PC_Write, Branch_Taken, Branch_Target,
               ID_EX_Bubble, Stall_Count, Flush_Count
    );

    modport slave (
        input  IF_Instr, IF_PC_Plus4, RF_Read1, RF_Read2,
               ID_Forward_1, ID_Forward_2, EX_MEM_ALUOut, MEM_WB_WriteData,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
        output IF_ID_Instr, IF_ID_PC_Plus4, IF_ID_Rs, IF_ID_Rt,
               ID_Rs_Data, ID_Rt_Data, PC_Write, Branch_Taken, Branch_Target,
               ID_EX_Bubble, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/if_id_branch_stage.sv
// ---------------------------------------------------------------------------
// if_id_branch_stage
//   IF/ID pipeline register with ID-stage beq/bne resolution and hazard
//   stall generation for a 5-stage MIPS pipeline.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears IF/ID to a NOP and the counters
//   bus    : if_id_branch_stage_if.slave
//            in  : IF_Instr, IF_PC_Plus4, RF_Read1/2, ID_Forward_1/2,
//                  EX_MEM_ALUOut, MEM_WB_WriteData, ID_EX_RegWrite,
//                  ID_EX_MemRead, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd
//            out : IF_ID_Instr, IF_ID_PC_Plus4, IF_ID_Rs, IF_ID_Rt,
//                  ID_Rs_Data, ID_Rt_Data, PC_Write, Branch_Taken,
//                  Branch_Target, ID_EX_Bubble, Stall_Count, Flush_Count
// ---------------------------------------------------------------------------
module if_id_branch_stage #(
    parameter int DATA_W     = 32,
    parameter int PERF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    if_id_branch_stage_if.slave  bus
);
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    logic [DATA_W-1:0]     instr_q, instr_d;
    logic [DATA_W-1:0]     pc4_q, pc4_d;
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [5:0]               opcode;
    logic [4:0]               rs, rt;
    logic                     is_branch;
    logic                     load_use, br_ex, br_load, stall;
    logic                     taken;
    logic [DATA_W-1:0]        rs_data, rt_data;
    logic signed [DATA_W-1:0] br_off;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

    // Code 2'b11 is unused by the forwarding unit and falls back to the RF value.
    function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0]        code,
                                                  input logic [DATA_W-1:0] rf,
                                                  input logic [DATA_W-1:0] ex_mem,
                                                  input logic [DATA_W-1:0] mem_wb);
        case (code)
            2'b01:   return ex_mem;
            2'b10:   return mem_wb;
            default: return rf;
        endcase
    endfunction

    // $zero never carries a real dependency.
    function automatic logic hz_match(input logic [4:0] rd,
                                      input logic [4:0] src_s,
                                      input logic [4:0] src_t);
        return (rd != 5'd0) && ((rd == src_s) || (rd == src_t));
    endfunction

    // ---- ID stage: decode, operand select, hazard and branch resolution ----
    always_comb begin
        opcode    = instr_q[31:26];
        rs        = instr_q[25:21];
        rt        = instr_q[20:16];
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

        rs_data = fwd_sel(bus.ID_Forward_1, bus.RF_Read1, bus.EX_MEM_ALUOut, bus.MEM_WB_WriteData);
        rt_data = fwd_sel(bus.ID_Forward_2, bus.RF_Read2, bus.EX_MEM_ALUOut, bus.MEM_WB_WriteData);

        load_use = bus.ID_EX_MemRead && hz_match(bus.ID_EX_Rd, rs, rt);
        // A branch compares in ID, so it must also wait for an ALU result
        // still in EX and for a load result still in MEM.
        br_ex    = is_branch && bus.ID_EX_RegWrite && hz_match(bus.ID_EX_Rd, rs, rt);
        br_load  = is_branch && bus.EX_MEM_MemRead && hz_match(bus.EX_MEM_Rd, rs, rt);
        stall    = load_use || br_ex || br_load;

        // Stall dominates: a branch with stale operands must not redirect.
        taken = !stall && is_branch &&
                ((opcode == OP_BEQ) ? (rs_data == rt_data) : (rs_data != rt_data));

        br_off = $signed({{(DATA_W-16){instr_q[15]}}, instr_q[15:0]}) <<< 2;
    end

    // ---- IF/ID register next state ----
    always_comb begin
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (taken) begin
            // The wrong-path fetch is squashed into a NOP; its PC+4 is kept.
            instr_d     = '0;
            pc4_d       = bus.IF_PC_Plus4;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            instr_d = bus.IF_Instr;
            pc4_d   = bus.IF_PC_Plus4;
        end
    end

    // ---- IF -> ID boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= '0;
            pc4_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.IF_ID_Instr    = instr_q;
    assign bus.IF_ID_PC_Plus4 = pc4_q;
    assign bus.IF_ID_Rs       = rs;
    assign bus.IF_ID_Rt       = rt;
    assign bus.ID_Rs_Data     = rs_data;
    assign bus.ID_Rt_Data     = rt_data;
    assign bus.PC_Write       = !stall;
    assign bus.Branch_Taken   = taken;
    assign bus.Branch_Target  = pc4_q + $unsigned(br_off);
    assign bus.ID_EX_Bubble   = stall;
    assign bus.Stall_Count    = stall_cnt_q;
    assign bus.Flush_Count    = flush_cnt_q;
endmodule

// File: tb/tb_if_id_branch_stage.sv
module tb_if_id_branch_stage;
    logic clk;
    logic reset;

    if_id_branch_stage_if #(.DATA_W(32), .PERF_CNT_W(16)) bus   ();
    if_id_branch_stage_if #(.DATA_W(32), .PERF_CNT_W(2))  bus_s ();

    if_id_branch_stage #(.DATA_W(32), .PERF_CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus));
    if_id_branch_stage #(.DATA_W(32), .PERF_CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    // Narrow-counter instance sees exactly the same stimulus.
    assign bus_s.IF_Instr         = bus.IF_Instr;
    assign bus_s.IF_PC_Plus4      = bus.IF_PC_Plus4;
    assign bus_s.RF_Read1         = bus.RF_Read1;
    assign bus_s.RF_Read2         = bus.RF_Read2;
    assign bus_s.ID_Forward_1     = bus.ID_Forward_1;
    assign bus_s.ID_Forward_2     = bus.ID_Forward_2;
    assign bus_s.EX_MEM_ALUOut    = bus.EX_MEM_ALUOut;
    assign bus_s.MEM_WB_WriteData = bus.MEM_WB_WriteData;
    assign bus_s.ID_EX_RegWrite   = bus.ID_EX_RegWrite;
    assign bus_s.ID_EX_MemRead    = bus.ID_EX_MemRead;
    assign bus_s.ID_EX_Rd         = bus.ID_EX_Rd;
    assign bus_s.EX_MEM_MemRead   = bus.EX_MEM_MemRead;
    assign bus_s.EX_MEM_Rd        = bus.EX_MEM_Rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc4, rsd, rtd, tgt;
        logic [4:0]  rs, rt;
        logic        pcw, tk, bub;
        int          stall, flush;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: what IF/ID holds and how many events have occurred.
    logic [31:0] m_instr, m_pc4;
    int          m_stall, m_flush;

    localparam logic [31:0] ADD_10_8_9   = 32'h0109_5020;  // add $10,$8,$9
    localparam logic [31:0] BEQ_8_9_3    = 32'h1109_0003;  // beq $8,$9,3
    localparam logic [31:0] BNE_1_2_M1   = 32'h1422_FFFF;  // bne $1,$2,-1

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] code, input logic [31:0] rf);
        if (code == 2'b01) return bus.EX_MEM_ALUOut;
        if (code == 2'b10) return bus.MEM_WB_WriteData;
        return rf;
    endfunction

    function automatic logic depends(input logic [4:0] rd, input logic [31:0] ins);
        return rd != 0 && (rd == ins[25:21] || rd == ins[20:16]);
    endfunction

    // Predict this cycle's ID outputs, queue them, then advance the model one edge.
    task automatic apply();
        exp_t        e;
        logic [5:0]  op;
        logic        br, hold, tk;
        op   = m_instr[31:26];
        br   = (op == 6'h04) || (op == 6'h05);
        hold = (bus.ID_EX_MemRead && depends(bus.ID_EX_Rd, m_instr))
            || (br && bus.ID_EX_RegWrite && depends(bus.ID_EX_Rd, m_instr))
            || (br && bus.EX_MEM_MemRead && depends(bus.EX_MEM_Rd, m_instr));
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.rs    = m_instr[25:21];
        e.rt    = m_instr[20:16];
        e.rsd   = pick(bus.ID_Forward_1, bus.RF_Read1);
        e.rtd   = pick(bus.ID_Forward_2, bus.RF_Read2);
        tk      = !hold && br && ((op == 6'h04) == (e.rsd == e.rtd));
        e.tk    = tk;
        e.pcw   = !hold;
        e.bub   = hold;
        e.tgt   = m_pc4 + 32'(int'($signed(m_instr[15:0])) * 4);
        e.stall = m_stall;
        e.flush = m_flush;
        q.push_back(e);
        if (reset) begin
            m_instr = 0; m_pc4 = 0; m_stall = 0; m_flush = 0;
        end else if (hold) begin
            m_stall++;
        end else if (tk) begin
            m_instr = 0; m_pc4 = bus.IF_PC_Plus4; m_flush++;
        end else begin
            m_instr = bus.IF_Instr; m_pc4 = bus.IF_PC_Plus4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        reset                = 1'b0;
        bus.IF_Instr         = '0;
        bus.IF_PC_Plus4      = '0;
        bus.RF_Read1         = '0;
        bus.RF_Read2         = '0;
        bus.ID_Forward_1     = 2'b00;
        bus.ID_Forward_2     = 2'b00;
        bus.EX_MEM_ALUOut    = '0;
        bus.MEM_WB_WriteData = '0;
        bus.ID_EX_RegWrite   = 1'b0;
        bus.ID_EX_MemRead    = 1'b0;
        bus.ID_EX_Rd         = '0;
        bus.EX_MEM_MemRead   = 1'b0;
        bus.EX_MEM_Rd        = '0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 4))
            0:       op = 6'h00;
            1, 2:    op = 6'h04;
            3:       op = 6'h05;
            default: op = 6'h23;
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    // Monitor: every cycle the DUT presents a full set of ID outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("IF_ID_Instr",    64'(bus.IF_ID_Instr),    64'(e.instr));
                chk("IF_ID_PC_Plus4", 64'(bus.IF_ID_PC_Plus4), 64'(e.pc4));
                chk("IF_ID_Rs",       64'(bus.IF_ID_Rs),       64'(e.rs));
                chk("IF_ID_Rt",       64'(bus.IF_ID_Rt),       64'(e.rt));
                chk("ID_Rs_Data",     64'(bus.ID_Rs_Data),     64'(e.rsd));
                chk("ID_Rt_Data",     64'(bus.ID_Rt_Data),     64'(e.rtd));
                chk("PC_Write",       64'(bus.PC_Write),       64'(e.pcw));
                chk("ID_EX_Bubble",   64'(bus.ID_EX_Bubble),   64'(e.bub));
                chk("Branch_Taken",   64'(bus.Branch_Taken),   64'(e.tk));
                if (e.tk) chk("Branch_Target", 64'(bus.Branch_Target), 64'(e.tgt));
                chk("Stall_Count",    64'(bus.Stall_Count),    64'(sat(e.stall, 16)));
                chk("Flush_Count",    64'(bus.Flush_Count),    64'(sat(e.flush, 16)));
                chk("Stall_Count_w2", 64'(bus_s.Stall_Count),  64'(sat(e.stall, 2)));
                chk("Flush_Count_w2", 64'(bus_s.Flush_Count),  64'(sat(e.flush, 2)));
            end
        end
    end

    initial begin
        quiet();
        reset = 1'b1;
        tick();
        m_instr = 0; m_pc4 = 0; m_stall = 0; m_flush = 0;

        // T1: reset state
        apply();
        @(negedge clk);
        chk("T1 instr",  64'(bus.IF_ID_Instr),  64'h0);
        chk("T1 pcw",    64'(bus.PC_Write),     64'h1);
        chk("T1 taken",  64'(bus.Branch_Taken), 64'h0);
        chk("T1 bubble", 64'(bus.ID_EX_Bubble), 64'h0);
        chk("T1 stall",  64'(bus.Stall_Count),  64'h0);
        chk("T1 flush",  64'(bus.Flush_Count),  64'h0);
        tick();

        // T2: load-use on $8
        reset = 1'b0;
        bus.IF_Instr = ADD_10_8_9; bus.IF_PC_Plus4 = 32'h0000_0040;
        apply(); tick();
        bus.IF_Instr = 32'h0; bus.IF_PC_Plus4 = 32'h0000_0044;
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rd = 5'd8;
        apply();
        @(negedge clk);
        chk("T2 pcw",    64'(bus.PC_Write),     64'h0);
        chk("T2 bubble", 64'(bus.ID_EX_Bubble), 64'h1);
        tick();
        chk("T2 held",   64'(bus.IF_ID_Instr),  64'(ADD_10_8_9));
        chk("T2 stall",  64'(bus.Stall_Count),  64'h1);

        // T3: beq taken with EX/MEM forwarding on Rs
        quiet();
        bus.IF_Instr = BEQ_8_9_3; bus.IF_PC_Plus4 = 32'h0000_0100;
        apply(); tick();
        bus.IF_Instr = ADD_10_8_9; bus.IF_PC_Plus4 = 32'h0000_0104;
        bus.ID_Forward_1 = 2'b01; bus.EX_MEM_ALUOut = 32'd5; bus.RF_Read2 = 32'd5;
        bus.RF_Read1 = 32'd9;
        apply();
        @(negedge clk);
        chk("T3 taken",  64'(bus.Branch_Taken),  64'h1);
        chk("T3 target", 64'(bus.Branch_Target), 64'h10C);
        tick();
        chk("T3 flushed", 64'(bus.IF_ID_Instr),    64'h0);
        chk("T3 pc4",     64'(bus.IF_ID_PC_Plus4), 64'h104);
        chk("T3 flush",   64'(bus.Flush_Count),    64'h1);

        // T4: branch depends on ALU result in EX, then resolves via Fwd2
        quiet();
        bus.IF_Instr = BEQ_8_9_3; bus.IF_PC_Plus4 = 32'h0000_0200;
        apply(); tick();
        bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Rd = 5'd9;
        bus.RF_Read1 = 32'd7; bus.RF_Read2 = 32'd7;
        apply();
        @(negedge clk);
        chk("T4 taken", 64'(bus.Branch_Taken), 64'h0);
        chk("T4 pcw",   64'(bus.PC_Write),     64'h0);
        tick();
        bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_Rd = 5'd0;
        bus.ID_Forward_2 = 2'b01; bus.EX_MEM_ALUOut = 32'd7; bus.RF_Read2 = 32'd1;
        apply();
        @(negedge clk);
        chk("T4 resolved", 64'(bus.Branch_Taken), 64'h1);
        chk("T4 stall",    64'(bus.Stall_Count),  64'h2);
        tick();

        // T5: bne backward, target wraps
        quiet();
        bus.IF_Instr = BNE_1_2_M1; bus.IF_PC_Plus4 = 32'h0;
        apply(); tick();
        bus.RF_Read1 = 32'd1; bus.RF_Read2 = 32'd2;
        apply();
        @(negedge clk);
        chk("T5 taken",  64'(bus.Branch_Taken),  64'h1);
        chk("T5 target", 64'(bus.Branch_Target), 64'hFFFF_FFFC);
        tick();

        // T6: 2-bit counter saturation, then reset mid-stall
        quiet();
        reset = 1'b1;
        apply(); tick();
        reset = 1'b0;
        bus.IF_Instr = ADD_10_8_9;
        apply(); tick();
        bus.IF_Instr = 32'h0;
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rd = 5'd8;
        for (int i = 0; i < 5; i++) begin
            apply(); tick();
            chk("T6 sat", 64'(bus_s.Stall_Count), 64'((i < 3) ? i + 1 : 3));
        end
        reset = 1'b1;
        apply(); tick();
        chk("T6 rst cnt",   64'(bus_s.Stall_Count), 64'h0);
        chk("T6 rst instr", 64'(bus.IF_ID_Instr),   64'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            reset                = ($urandom_range(0, 40) == 0);
            bus.IF_Instr         = rand_instr();
            bus.IF_PC_Plus4      = $urandom & 32'hFFFF_FFFC;
            bus.RF_Read1         = 32'($urandom_range(0, 3));
            bus.RF_Read2         = 32'($urandom_range(0, 3));
            bus.ID_Forward_1     = 2'($urandom_range(0, 3));
            bus.ID_Forward_2     = 2'($urandom_range(0, 3));
            bus.EX_MEM_ALUOut    = 32'($urandom_range(0, 3));
            bus.MEM_WB_WriteData = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3));
            bus.ID_EX_RegWrite   = 1'($urandom_range(0, 1));
            bus.ID_EX_MemRead    = ($urandom_range(0, 3) == 0);
            bus.ID_EX_Rd         = 5'($urandom_range(0, 3));
            bus.EX_MEM_MemRead   = ($urandom_range(0, 3) == 0);
            bus.EX_MEM_Rd        = 5'($urandom_range(0, 3));
            apply(); tick();
        end

        for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
